// File: rtl/osc_reset_seq.sv
// osc_reset_seq: reset sequencer between the OSC/CCC clock stage and the
// core/peripheral reset inputs. Qualifies the CCC lock flag, releases
// peripheral reset and then core reset, and forces a minimum reset hold
// whenever lock is lost after release.
module osc_reset_seq #(
    parameter int STABLE_CYCLES = 1024,
    parameter int CORE_DELAY    = 16,
    parameter int HOLD_CYCLES   = 64,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock_i,
    output logic       periph_rst_o,
    output logic       core_rst_o,
    output logic       ready_o,
    output logic       lock_lost_o,
    output logic [7:0] lost_count_o
);

    localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] ST_STABLE    = 3'd1;
    localparam logic [2:0] ST_PERIPH    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;

    // Terminal counts; the counter restarts from zero on every state entry,
    // so the last value of each phase is the phase length minus one.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_DELAY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             lock_s;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             loss;

    assign lock_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous CCC lock flag.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours, as real flops do.
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], lock_i};
        end
    end

    // Next-state and counter decode; lock loss is only meaningful once
    // peripheral reset has been released (PERIPH or RUN).
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case can leave a value unassigned (no latches).
        state_nxt = state;
        cnt_nxt   = cnt;
        loss      = 1'b0;
        case (state)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    // Lock glitched before qualification: start over quietly.
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_PERIPH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_PERIPH: begin
                if (!lock_s) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                    loss      = 1'b1;
                end else if (cnt == CORE_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                    loss      = 1'b1;
                end
            end
            ST_HOLD: begin
                // Lock is ignored here; the hold always runs its full length.
                if (cnt == HOLD_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs, all driven from the next state
    // so the ports change on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_WAIT_LOCK;
            cnt          <= '0;
            periph_rst_o <= 1'b1;
            core_rst_o   <= 1'b1;
            ready_o      <= 1'b0;
            lock_lost_o  <= 1'b0;
            lost_count_o <= 8'd0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            periph_rst_o <= !((state_nxt == ST_PERIPH) || (state_nxt == ST_RUN));
            core_rst_o   <= (state_nxt != ST_RUN);
            ready_o      <= (state_nxt == ST_RUN);
            lock_lost_o  <= loss;
            if (loss && (lost_count_o != 8'hFF)) begin
                lost_count_o <= lost_count_o + 8'd1;
            end
        end
    end

endmodule
